// File: rtl/uart_transmitter.sv
`timescale 1ns/1ps
// UART 8N1 transmitter with an internal byte FIFO.
// Frames are sent LSB first, back to back while the FIFO holds data.
module uart_transmitter #(
  parameter int CLK_PER_HALF_BIT = 434,
  parameter int FIFO_DEPTH       = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [7:0]                  data_in,
  input  logic                        valid_in,
  output logic                        ready_in,
  output logic                        UART_TX,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int BIT = 2 * CLK_PER_HALF_BIT;
  localparam int CW  = $clog2(BIT);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int NW  = AW + 1;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bitidx_q;
  logic [7:0]    shreg_q;
  logic          tx_q;
  logic          busy_q;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [NW-1:0] count_q;
  logic [NW-1:0] count_d;

  logic push;
  logic pop;
  logic bit_end;
  logic nonempty;

  assign ready_in   = (count_q != NW'(FIFO_DEPTH));
  assign nonempty   = (count_q != '0);
  assign push       = valid_in && ready_in;
  assign bit_end    = (cnt_q == CW'(BIT - 1));
  assign pop        = nonempty &&
                      ((state_q == IDLE) ||
                       ((state_q == STOP) && bit_end));

  assign UART_TX    = tx_q;
  assign busy       = busy_q;
  assign fifo_count = count_q;

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + NW'(1);
      2'b01:   count_d = count_q - NW'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + AW'(1);
      if (pop)  rd_q <= rd_q + AW'(1);
      count_q <= count_d;
    end
  end

  // Storage needs no reset: pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push && !rst) mem_q[wr_q] <= data_in;
  end

  // Line level follows the state of the previous cycle, one register late.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bitidx_q <= '0;
      shreg_q  <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      busy_q <= (state_q != IDLE) || nonempty;
      cnt_q  <= bit_end ? '0 : cnt_q + CW'(1);
      unique case (state_q)
        IDLE: begin
          tx_q  <= 1'b1;
          cnt_q <= '0;
          if (nonempty) begin
            shreg_q <= mem_q[rd_q];
            state_q <= START;
          end
        end
        START: begin
          tx_q <= 1'b0;
          if (bit_end) begin
            bitidx_q <= '0;
            state_q  <= DATA;
          end
        end
        DATA: begin
          tx_q <= shreg_q[0];
          if (bit_end) begin
            shreg_q  <= shreg_q >> 1;
            bitidx_q <= bitidx_q + 3'd1;
            if (bitidx_q == 3'd7) state_q <= STOP;
          end
        end
        STOP: begin
          tx_q <= 1'b1;
          if (bit_end) begin
            if (nonempty) begin
              shreg_q <= mem_q[rd_q];
              state_q <= START;
            end else begin
              state_q <= IDLE;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
`timescale 1ns/1ps
// Bench for uart_transmitter: small fast instance plus a full-rate one.
// Reference receiver samples mid-bit and reports frame gaps.
module tb_uart_transmitter;

  localparam int HB0  = 4;
  localparam int BIT0 = 8;
  localparam int DEP0 = 4;
  localparam int HB1  = 434;
  localparam int BIT1 = 868;
  localparam int DEP1 = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data0, data1;
  logic       valid0, valid1;
  logic       ready0, ready1;
  logic       tx0, tx1;
  logic       busy0, busy1;
  logic [2:0] cnt0;
  logic [4:0] cnt1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [7:0] data;
    logic [9:0] lvl;
  } vec_t;

  vec_t       vt [5];
  logic [7:0] arr [8];

  always #5 clk = ~clk;

  uart_transmitter #(
    .CLK_PER_HALF_BIT(HB0),
    .FIFO_DEPTH(DEP0)
  ) u0 (
    .clk(clk),
    .rst(rst),
    .data_in(data0),
    .valid_in(valid0),
    .ready_in(ready0),
    .UART_TX(tx0),
    .busy(busy0),
    .fifo_count(cnt0)
  );

  uart_transmitter #(
    .CLK_PER_HALF_BIT(HB1),
    .FIFO_DEPTH(DEP1)
  ) u1 (
    .clk(clk),
    .rst(rst),
    .data_in(data1),
    .valid_in(valid1),
    .ready_in(ready1),
    .UART_TX(tx1),
    .busy(busy1),
    .fifo_count(cnt1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic line(input int w);
    return (w == 0) ? tx0 : tx1;
  endfunction

  function automatic logic bsy(input int w);
    return (w == 0) ? busy0 : busy1;
  endfunction

  function automatic logic rdy(input int w);
    return (w == 0) ? ready0 : ready1;
  endfunction

  function automatic int cntf(input int w);
    return (w == 0) ? int'(cnt0) : int'(cnt1);
  endfunction

  task automatic drive(input int w, input logic [7:0] d, input logic v);
    if (w == 0) begin
      data0  = d;
      valid0 = v;
    end else begin
      data1  = d;
      valid1 = v;
    end
  endtask

  // Waits for a start bit, then samples each bit in its middle.
  task automatic rx_byte(input int w, input int bl, input int limit,
                         output logic [7:0] b, output logic sb,
                         output int waited, output bit to);
    waited = 0;
    to     = 1'b0;
    b      = '0;
    sb     = 1'b0;
    while (line(w) !== 1'b0) begin
      if (waited >= limit) begin
        to = 1'b1;
        return;
      end
      step();
      waited++;
    end
    repeat (bl / 2) step();
    for (int i = 0; i < 8; i++) begin
      repeat (bl) step();
      b[i] = line(w);
    end
    repeat (bl) step();
    sb = line(w);
  endtask

  task automatic quiet(input int w, input int cyc, input string nm);
    bit bad;
    bad = 1'b0;
    for (int i = 0; i < cyc; i++) begin
      step();
      if (line(w) !== 1'b1) bad = 1'b1;
    end
    chk({nm, "_line_idle"}, bad, 0);
    chk({nm, "_busy_low"}, bsy(w), 0);
    chk({nm, "_count_zero"}, cntf(w), 0);
  endtask

  // Pushes n bytes on consecutive cycles starting from idle. The first
  // byte leaves for the shifter one cycle after its push, so depth+1
  // bytes are taken and the rest are refused.
  task automatic run_burst(input int w, input int bl, input int depth,
                           input logic [7:0] d [8], input int n,
                           input string tag);
    int m;
    m = (n > depth + 1) ? depth + 1 : n;
    fork
      begin
        for (int k = 0; k < n; k++) begin
          drive(w, d[k], 1'b1);
          chk($sformatf("%s_ready_%0d", tag, k), rdy(w), (k <= depth));
          step();
        end
        drive(w, 8'h00, 1'b0);
      end
      begin
        logic [7:0] b;
        logic       sb;
        int         wt;
        bit         to;
        for (int i = 0; i < m; i++) begin
          rx_byte(w, bl, 4 * bl, b, sb, wt, to);
          chk($sformatf("%s_timeout_%0d", tag, i), to, 0);
          if (to) break;
          chk($sformatf("%s_byte_%0d", tag, i), b, d[i]);
          chk($sformatf("%s_stop_%0d", tag, i), sb, 1);
          if (i > 0) chk($sformatf("%s_gap_%0d", tag, i), wt, bl / 2);
        end
      end
    join
    quiet(w, 3 * bl, tag);
  endtask

  initial begin
    logic [7:0] b;
    logic       sb;
    int         wt;
    bit         to;
    int         n;

    vt[0] = '{8'h55, 10'b1010101010};
    vt[1] = '{8'hA3, 10'b1101000110};
    vt[2] = '{8'h00, 10'b1000000000};
    vt[3] = '{8'hFF, 10'b1111111110};
    vt[4] = '{8'h3C, 10'b1001111000};

    // Reset with valid held high: nothing may be queued.
    rst = 1'b1;
    drive(0, 8'hEE, 1'b1);
    drive(1, 8'hEE, 1'b1);
    repeat (3) step();
    rst = 1'b0;
    drive(0, 8'h00, 1'b0);
    drive(1, 8'h00, 1'b0);
    chk("rst_tx0", tx0, 1);
    chk("rst_busy0", busy0, 0);
    chk("rst_count0", cnt0, 0);
    chk("rst_ready0", ready0, 1);
    chk("rst_tx1", tx1, 1);
    chk("rst_busy1", busy1, 0);
    chk("rst_count1", cnt1, 0);
    chk("rst_ready1", ready1, 1);
    quiet(0, 12, "rst_post");

    // Single frames, checked every cycle.
    for (int i = 0; i < 5; i++) begin
      drive(0, vt[i].data, 1'b1);
      step();
      drive(0, 8'h00, 1'b0);
      chk($sformatf("t1_%0h_lat0", vt[i].data), tx0, 1);
      step();
      chk($sformatf("t1_%0h_lat1", vt[i].data), tx0, 1);
      for (int j = 0; j < 10 * BIT0; j++) begin
        step();
        chk($sformatf("t1_%0h_bit_c%0d", vt[i].data, j), tx0,
            vt[i].lvl[j / BIT0]);
        chk($sformatf("t1_%0h_busy_c%0d", vt[i].data, j), busy0, 1);
      end
      step();
      chk($sformatf("t1_%0h_end_tx", vt[i].data), tx0, 1);
      chk($sformatf("t1_%0h_end_busy", vt[i].data), busy0, 0);
      chk($sformatf("t1_%0h_end_count", vt[i].data), cnt0, 0);
    end

    // Two contiguous frames.
    arr[0] = 8'hA3;
    arr[1] = 8'h0F;
    run_burst(0, BIT0, DEP0, arr, 2, "t2");

    // Six pushes, the sixth refused.
    for (int i = 0; i < 6; i++) arr[i] = 8'h31 + 8'(i);
    run_burst(0, BIT0, DEP0, arr, 6, "t3");

    // Push attempt on the very edge the FSM pops from a full FIFO.
    for (int k = 0; k < 5; k++) begin
      drive(0, 8'h10 + 8'(k), 1'b1);
      step();
    end
    drive(0, 8'h00, 1'b0);
    repeat (10 * BIT0 - 4) step();
    chk("t4_count_full", cnt0, 4);
    chk("t4_ready_full", ready0, 0);
    drive(0, 8'h77, 1'b1);
    step();
    drive(0, 8'h00, 1'b0);
    chk("t4_count_after", cnt0, 3);
    chk("t4_ready_after", ready0, 1);
    for (int i = 1; i < 5; i++) begin
      rx_byte(0, BIT0, 4 * BIT0, b, sb, wt, to);
      chk($sformatf("t4_timeout_%0d", i), to, 0);
      if (to) break;
      chk($sformatf("t4_byte_%0d", i), b, 8'h10 + 8'(i));
      chk($sformatf("t4_stop_%0d", i), sb, 1);
      chk($sformatf("t4_gap_%0d", i), wt, (i == 1) ? 1 : BIT0 / 2);
    end
    quiet(0, 3 * BIT0, "t4");

    // Reset in data bit 3 of 0xFF with two more bytes queued.
    arr[0] = 8'hFF;
    arr[1] = 8'h00;
    arr[2] = 8'h00;
    for (int k = 0; k < 3; k++) begin
      drive(0, arr[k], 1'b1);
      step();
    end
    drive(0, 8'h00, 1'b0);
    repeat (33) step();
    chk("t5_pre_tx", tx0, 1);
    chk("t5_pre_busy", busy0, 1);
    chk("t5_pre_count", cnt0, 2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t5_tx", tx0, 1);
    chk("t5_count", cnt0, 0);
    chk("t5_busy", busy0, 0);
    chk("t5_ready", ready0, 1);
    quiet(0, 30 * BIT0, "t5");

    // Reset during a low start bit.
    drive(0, 8'h00, 1'b1);
    step();
    drive(0, 8'h00, 1'b0);
    step();
    step();
    chk("t5b_start_low", tx0, 0);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t5b_tx", tx0, 1);
    quiet(0, 12 * BIT0, "t5b");

    // Random bursts against the accept-first-depth+1 rule.
    for (int it = 0; it < 8; it++) begin
      n = $urandom_range(1, 7);
      for (int i = 0; i < 8; i++) arr[i] = 8'($urandom);
      run_burst(0, BIT0, DEP0, arr, n, $sformatf("rnd%0d", it));
    end

    // Full-rate instance.
    arr[0] = 8'h00;
    arr[1] = 8'hFF;
    arr[2] = 8'h80;
    run_burst(1, BIT1, DEP1, arr, 3, "t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
